// File: rtl/vit_3by4_dec_trb_ctrl.sv
// Traceback scheduler for the 3/4 Viterbi decoder: survivor RAM write addressing,
// decision-tree alignment and sliding-window / flush traceback job issue.
module vit_3by4_dec_trb_ctrl #(
  parameter int pSTATE_W = 6,
  parameter int pADDR_W  = 7,
  parameter int pTRB_LEN = 32,
  parameter int pDEC_LEN = 16,
  parameter int pDEC_LAT = 6
) (
  input  logic                iclk,
  input  logic                iresetn,
  input  logic                iclkena,
  input  logic                ival,
  input  logic                isop,
  input  logic                ieop,
  output logic                owrite,
  output logic [pADDR_W-1:0]  owaddr,
  input  logic [pSTATE_W-1:0] idec_state,
  output logic                otrb_start,
  output logic [pADDR_W-1:0]  otrb_addr,
  output logic [pSTATE_W-1:0] otrb_state,
  output logic [pADDR_W-1:0]  otrb_skip,
  output logic [pADDR_W-1:0]  otrb_len,
  output logic                otrb_eop,
  input  logic                itrb_ready,
  output logic                obusy,
  output logic                oerr
);

  localparam logic [pADDR_W-1:0] cTRIG = pADDR_W'(pTRB_LEN + pDEC_LEN);
  localparam logic [pADDR_W-1:0] cSKIP = pADDR_W'(pTRB_LEN);
  localparam logic [pADDR_W-1:0] cLEN  = pADDR_W'(pDEC_LEN);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, state_nxt;
  logic [pADDR_W-1:0]   wptr;
  logic [pDEC_LAT-1:0]  dl_val, dl_sop, dl_eop;
  logic [pADDR_W-1:0]   dl_addr [pDEC_LAT];
  logic                 d_val, d_sop, d_eop;
  logic [pADDR_W-1:0]   d_addr;
  logic [pADDR_W-1:0]   pend, pend_nxt, pend_inc;
  logic                 trig, trig_eop, frame_err, drop, load;
  logic [pADDR_W-1:0]   trig_skip, trig_len;

  assign owrite = ival & iclkena;
  assign owaddr = wptr;
  assign obusy  = (state != IDLE) | otrb_start;

  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      wptr <= '0;
    end else if (iclkena && ival) begin
      wptr <= wptr + 1'b1;
    end
  end

  // Symbol descriptors ride alongside the decision tree pipeline so the delayed
  // entry meets the best state computed for the same survivor word.
  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      dl_val <= '0;
      dl_sop <= '0;
      dl_eop <= '0;
      for (int i = 0; i < pDEC_LAT; i++) dl_addr[i] <= '0;
    end else if (iclkena) begin
      dl_val[0]  <= ival;
      dl_sop[0]  <= ival & isop;
      dl_eop[0]  <= ival & ieop;
      dl_addr[0] <= wptr;
      for (int i = 1; i < pDEC_LAT; i++) begin
        dl_val[i]  <= dl_val[i-1];
        dl_sop[i]  <= dl_sop[i-1];
        dl_eop[i]  <= dl_eop[i-1];
        dl_addr[i] <= dl_addr[i-1];
      end
    end
  end

  assign d_val  = dl_val[pDEC_LAT-1];
  assign d_sop  = dl_sop[pDEC_LAT-1];
  assign d_eop  = dl_eop[pDEC_LAT-1];
  assign d_addr = dl_addr[pDEC_LAT-1];

  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      state <= IDLE;
    end else if (iclkena) begin
      state <= state_nxt;
    end
  end

  // pend counts delivered-but-not-yet-output symbols, including the previous one;
  // pend_inc is that count once the current delayed symbol is added.
  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    pend_inc  = pend + 1'b1;
    trig      = 1'b0;
    trig_eop  = 1'b0;
    trig_skip = '0;
    trig_len  = '0;
    frame_err = 1'b0;
    if (d_val) begin
      if (d_sop) begin
        frame_err = (state == RUN);
        if (d_eop) begin
          trig      = 1'b1;
          trig_eop  = 1'b1;
          trig_len  = pADDR_W'(1);
          pend_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          pend_nxt  = pADDR_W'(1);
          state_nxt = RUN;
        end
      end else if (state == RUN) begin
        if (d_eop) begin
          trig      = 1'b1;
          trig_eop  = 1'b1;
          trig_len  = pend_inc;
          pend_nxt  = '0;
          state_nxt = IDLE;
        end else if (pend_inc == cTRIG) begin
          trig      = 1'b1;
          trig_skip = cSKIP;
          trig_len  = cLEN;
          pend_nxt  = cSKIP;
        end else begin
          pend_nxt  = pend_inc;
        end
      end
    end
  end

  assign load = trig & (~otrb_start | itrb_ready);
  assign drop = trig & otrb_start & ~itrb_ready;

  // Single job register: a new job may replace one being accepted this cycle,
  // otherwise it is dropped and the pending job is left untouched.
  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      pend       <= '0;
      oerr       <= 1'b0;
      otrb_start <= 1'b0;
      otrb_addr  <= '0;
      otrb_state <= '0;
      otrb_skip  <= '0;
      otrb_len   <= '0;
      otrb_eop   <= 1'b0;
    end else if (iclkena) begin
      pend <= pend_nxt;
      oerr <= frame_err | drop;
      if (load) begin
        otrb_start <= 1'b1;
        otrb_addr  <= d_addr;
        otrb_state <= idec_state;
        otrb_skip  <= trig_skip;
        otrb_len   <= trig_len;
        otrb_eop   <= trig_eop;
      end else if (otrb_start && itrb_ready) begin
        otrb_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vit_3by4_dec_trb_ctrl.sv
// Scoreboard bench for the traceback scheduler: a per-symbol frame model predicts
// jobs and error pulses; a monitor compares every accepted job.
module tb_vit_3by4_dec_trb_ctrl;

  localparam int SW  = 6;
  localparam int AW  = 7;
  localparam int L   = 32;
  localparam int D   = 16;
  localparam int LAT = 6;

  logic          iclk, iresetn, iclkena, ival, isop, ieop;
  logic          owrite;
  logic [AW-1:0] owaddr;
  logic [SW-1:0] idec_state;
  logic          otrb_start;
  logic [AW-1:0] otrb_addr;
  logic [SW-1:0] otrb_state;
  logic [AW-1:0] otrb_skip, otrb_len;
  logic          otrb_eop, itrb_ready, obusy, oerr;

  vit_3by4_dec_trb_ctrl dut (
    .iclk(iclk), .iresetn(iresetn), .iclkena(iclkena), .ival(ival), .isop(isop), .ieop(ieop),
    .owrite(owrite), .owaddr(owaddr), .idec_state(idec_state), .otrb_start(otrb_start),
    .otrb_addr(otrb_addr), .otrb_state(otrb_state), .otrb_skip(otrb_skip), .otrb_len(otrb_len),
    .otrb_eop(otrb_eop), .itrb_ready(itrb_ready), .obusy(obusy), .oerr(oerr)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [SW-1:0] st;
    logic [AW-1:0] skip;
    logic [AW-1:0] len;
    logic          eop;
  } job_t;

  job_t          expq[$];
  int            checks = 0, errors = 0;
  int            err_exp = 0, err_obs = 0;
  logic [SW-1:0] statetab [0:8191];
  int            nsym = 0;
  int            stub [LAT];
  int            m_addr = 0, m_pend = 0, m_fsym = 0, drop_at = -1;
  bit            m_inframe = 0;

  // Frame-level reference: each accepted symbol either opens a frame, closes it with
  // a flush covering everything still pending, or completes another L+D window.
  function automatic void model_symbol(int n, bit s, bit e);
    job_t j;
    j.addr = AW'(m_addr);
    j.st   = statetab[n];
    j.skip = '0;
    j.len  = '0;
    j.eop  = 1'b0;
    m_addr = (m_addr + 1) % (1 << AW);
    if (s) begin
      if (m_inframe) err_exp++;
      m_inframe = 1;
      m_pend = 0;
      m_fsym = 0;
    end
    if (!m_inframe) return;
    m_pend++;
    m_fsym++;
    if (e) begin
      j.len = AW'(m_pend);
      j.eop = 1'b1;
      expq.push_back(j);
      m_pend = 0;
      m_inframe = 0;
    end else if (m_pend == L + D) begin
      j.skip = AW'(L);
      j.len  = AW'(D);
      if (m_fsym == drop_at) err_exp++;
      else expq.push_back(j);
      m_pend = L;
    end
  endfunction

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One clock of stimulus; the stub pipeline plays the decision tree, presenting
  // each symbol's best state LAT enabled cycles after the symbol.
  task automatic applyStimulus(bit v, bit s, bit e, bit en);
    ival = v;
    isop = s;
    ieop = e;
    iclkena = en;
    idec_state = (stub[LAT-1] >= 0) ? statetab[stub[LAT-1]] : SW'($urandom);
    if (v && en) model_symbol(nsym, s, e);
    @(posedge iclk);
    if (en) begin
      for (int i = LAT-1; i > 0; i--) stub[i] = stub[i-1];
      stub[0] = v ? nsym : -1;
    end
    if (v && en) nsym++;
    #1;
  endtask

  task automatic send_frame(int len, bit with_eop, int gapp);
    for (int k = 1; k <= len; k++) begin
      while (int'($urandom_range(0, 9)) < gapp) applyStimulus(0, 0, 0, $urandom_range(0, 9) != 0);
      applyStimulus(1, k == 1, with_eop && k == len, 1);
    end
  endtask

  task automatic do_reset();
    iresetn = 1'b0;
    ival = 0; isop = 0; ieop = 0; iclkena = 1;
    #1;
    chk("reset_owaddr", owaddr, 0);
    chk("reset_start", otrb_start, 0);
    chk("reset_busy", obusy, 0);
    chk("reset_err", oerr, 0);
    repeat (2) @(posedge iclk);
    #1;
    for (int i = 0; i < LAT; i++) stub[i] = -1;
    m_addr = 0;
    m_pend = 0;
    m_inframe = 0;
    iresetn = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (expq.size() == 0 && !obusy) break;
      applyStimulus(0, 0, 0, 1);
    end
    chk("drain_done", int'(expq.size() == 0 && !obusy), 1);
  endtask

  // Monitor: each cycle that ends in an accepted job pops one expectation.
  initial begin : checkOutput
    job_t got, exp;
    forever begin
      @(negedge iclk);
      if (iresetn && iclkena) begin
        if (oerr) err_obs++;
        if (otrb_start && itrb_ready) begin
          got.addr = otrb_addr;
          got.st   = otrb_state;
          got.skip = otrb_skip;
          got.len  = otrb_len;
          got.eop  = otrb_eop;
          checks++;
          if (expq.size() == 0) begin
            errors++;
            $display("[TB] FAIL job_unexpected: got addr=%0d st=%0d skip=%0d len=%0d eop=%0d required none",
                     got.addr, got.st, got.skip, got.len, got.eop);
          end else begin
            exp = expq.pop_front();
            if (got !== exp) begin
              errors++;
              $display("[TB] FAIL job: got addr=%0d st=%0d skip=%0d len=%0d eop=%0d required addr=%0d st=%0d skip=%0d len=%0d eop=%0d",
                       got.addr, got.st, got.skip, got.len, got.eop,
                       exp.addr, exp.st, exp.skip, exp.len, exp.eop);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("[TB] FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    int e0, base;
    for (int i = 0; i < 8192; i++) statetab[i] = SW'($urandom);
    for (int i = 0; i < LAT; i++) stub[i] = -1;
    itrb_ready = 1'b1;
    idec_state = '0;
    do_reset();

    $display("[TB] reset in the middle of a frame");
    send_frame(40, 0, 0);
    applyStimulus(0, 0, 0, 1);
    do_reset();

    $display("[TB] 100-symbol frame, then 10- and 1-symbol frames");
    send_frame(100, 1, 0);
    send_frame(10, 1, 0);
    send_frame(1, 1, 0);
    drain();

    $display("[TB] engine stalled: second window dropped");
    do_reset();
    drop_at = 64;
    e0 = err_obs;
    base = nsym;
    itrb_ready = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (k == 76) begin
        chk("held_start", otrb_start, 1);
        chk("held_addr", otrb_addr, 47);
        chk("held_state", otrb_state, statetab[base + 47]);
        chk("held_len", otrb_len, D);
        chk("drop_err", err_obs - e0, 1);
        itrb_ready = 1'b1;
      end
      applyStimulus(1, k == 1, k == 100, 1);
    end
    drain();
    drop_at = -1;

    $display("[TB] 200-symbol frame with address wrap");
    do_reset();
    send_frame(200, 1, 0);
    chk("wrap_waddr", owaddr, 200 % 128);
    drain();

    $display("[TB] sop inside an open frame");
    e0 = err_obs;
    send_frame(29, 0, 0);
    send_frame(60, 1, 0);
    drain();
    chk("restart_err", err_obs - e0, 1);

    $display("[TB] randomized frames");
    for (int f = 0; f < 20; f++) begin
      send_frame($urandom_range(1, 150), (f == 19) || ($urandom_range(0, 4) != 0), 2);
      repeat ($urandom_range(0, 4)) applyStimulus(0, 0, 0, $urandom_range(0, 3) != 0);
    end
    drain();

    chk("err_count", err_obs, err_exp);
    chk("queue_empty", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
